// File: rtl/wb_arb_pkg.sv
// Shared definitions for the Wishbone round-robin arbiter: FSM encodings,
// default bus widths and small index helpers.
package wb_arb_pkg;

    localparam int DEFAULT_ADDR_W = 32;
    localparam int DEFAULT_DATA_W = 32;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_GRANT = 2'd1;
    localparam logic [1:0] ST_ABORT = 2'd2;

    function automatic int wrap_add(input int a, input int b, input int n);
        int s;
        s = a + b;
        return (s >= n) ? s - n : s;
    endfunction

    function automatic int wrap_inc(input int idx, input int n);
        return wrap_add(idx, 1, n);
    endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: first asserted request at or after ptr,
// wrapping modulo N. Returns a one-hot grant and the winning index.
module rr_priority_picker
    import wb_arb_pkg::*;
#(
    parameter int N     = 2,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    logic [IDX_W-1:0] cand;

    // NOTE: every output gets a default before the loop so no latch is inferred.
    always_comb begin
        grant = '0;
        idx   = '0;
        valid = 1'b0;
        cand  = '0;
        for (int i = 0; i < N; i++) begin
            cand = IDX_W'(wrap_add(int'(ptr), i, N));
            if (!valid && req[cand]) begin
                valid       = 1'b1;
                grant[cand] = 1'b1;
                idx         = cand;
            end
        end
    end

endmodule

// File: rtl/wishbone_rr_arbiter.sv
// Round-robin Wishbone B4 classic arbiter: grants whole bus cycles to one of
// NUM_MASTERS requesters, muxes it onto the slave, and aborts stalled strobes.
module wishbone_rr_arbiter
    import wb_arb_pkg::*;
#(
    parameter int NUM_MASTERS    = 2,
    parameter int ADDR_W         = DEFAULT_ADDR_W,
    parameter int DATA_W         = DEFAULT_DATA_W,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                            clk_i,
    input  logic                            rst_n_i,
    input  logic [NUM_MASTERS-1:0]          m_cyc_i,
    input  logic [NUM_MASTERS-1:0]          m_stb_i,
    input  logic [NUM_MASTERS-1:0]          m_we_i,
    input  logic [NUM_MASTERS*DATA_W/8-1:0] m_sel_i,
    input  logic [NUM_MASTERS*ADDR_W-1:0]   m_addr_i,
    input  logic [NUM_MASTERS*DATA_W-1:0]   m_data_i,
    output logic [DATA_W-1:0]               m_data_o,
    output logic [NUM_MASTERS-1:0]          m_ack_o,
    output logic [NUM_MASTERS-1:0]          m_err_o,
    output logic [NUM_MASTERS-1:0]          grant_o,
    output logic                            s_cyc_o,
    output logic                            s_stb_o,
    output logic                            s_we_o,
    output logic [DATA_W/8-1:0]             s_sel_o,
    output logic [ADDR_W-1:0]               s_addr_o,
    output logic [DATA_W-1:0]               s_data_o,
    input  logic [DATA_W-1:0]               s_data_i,
    input  logic                            s_ack_i
);

    localparam int SEL_W = DATA_W / 8;
    localparam int IDX_W = $clog2(NUM_MASTERS);
    localparam int WD_W  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [WD_W-1:0] WD_LAST = (TIMEOUT_CYCLES > 0) ? WD_W'(TIMEOUT_CYCLES - 1) : '0;

    logic [1:0]             state_q;
    logic [IDX_W-1:0]       owner_q;
    logic [IDX_W-1:0]       rr_ptr_q;
    logic [WD_W-1:0]        wd_cnt_q;

    logic [NUM_MASTERS-1:0] pick_grant;
    logic [IDX_W-1:0]       pick_idx;
    logic                   pick_valid;
    logic [NUM_MASTERS-1:0] owner_oh;
    logic [IDX_W-1:0]       mux_idx;
    logic [IDX_W-1:0]       ptr_after_owner;
    logic                   in_grant;
    logic                   owner_cyc;
    logic                   stalled;
    logic                   timeout_hit;

    rr_priority_picker #(
        .N     (NUM_MASTERS),
        .IDX_W (IDX_W)
    ) u_picker (
        .req   (m_cyc_i),
        .ptr   (rr_ptr_q),
        .grant (pick_grant),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    assign in_grant        = (state_q == ST_GRANT);
    assign owner_cyc       = m_cyc_i[owner_q];
    assign mux_idx         = (state_q == ST_IDLE) ? '0 : owner_q;
    assign ptr_after_owner = IDX_W'(wrap_inc(int'(owner_q), NUM_MASTERS));

    always_comb begin
        owner_oh          = '0;
        owner_oh[owner_q] = 1'b1;
    end

    always_comb begin
        s_we_o   = m_we_i[0];
        s_sel_o  = m_sel_i[SEL_W-1:0];
        s_addr_o = m_addr_i[ADDR_W-1:0];
        s_data_o = m_data_i[DATA_W-1:0];
        for (int i = 1; i < NUM_MASTERS; i++) begin
            if (mux_idx == IDX_W'(i)) begin
                s_we_o   = m_we_i[i];
                s_sel_o  = m_sel_i[i*SEL_W +: SEL_W];
                s_addr_o = m_addr_i[i*ADDR_W +: ADDR_W];
                s_data_o = m_data_i[i*DATA_W +: DATA_W];
            end
        end
    end

    assign s_cyc_o  = in_grant & owner_cyc;
    assign s_stb_o  = in_grant & m_stb_i[owner_q];
    assign m_data_o = s_data_i;
    assign grant_o  = (state_q != ST_IDLE) ? owner_oh : '0;
    // Acks arriving outside GRANT are dropped, never forwarded.
    assign m_ack_o  = (in_grant && s_ack_i) ? owner_oh : '0;
    assign m_err_o  = (state_q == ST_ABORT) ? owner_oh : '0;

    assign stalled     = s_stb_o & ~s_ack_i;
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && stalled && (wd_cnt_q == WD_LAST);

    // NOTE: sequential state uses non-blocking assignments; the async reset
    // clears only control state, the address/data path is purely combinational.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q  <= ST_IDLE;
            owner_q  <= '0;
            rr_ptr_q <= '0;
            wd_cnt_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    wd_cnt_q <= '0;
                    if (pick_valid) begin
                        owner_q <= pick_idx;
                        state_q <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    if (!owner_cyc) begin
                        state_q  <= ST_IDLE;
                        rr_ptr_q <= ptr_after_owner;
                        wd_cnt_q <= '0;
                    end else if (timeout_hit) begin
                        state_q  <= ST_ABORT;
                        wd_cnt_q <= '0;
                    end else if (stalled && TIMEOUT_CYCLES != 0) begin
                        wd_cnt_q <= wd_cnt_q + WD_W'(1);
                    end else begin
                        wd_cnt_q <= '0;
                    end
                end
                ST_ABORT: begin
                    wd_cnt_q <= '0;
                    if (owner_cyc) begin
                        state_q <= ST_GRANT;
                    end else begin
                        state_q  <= ST_IDLE;
                        rr_ptr_q <= ptr_after_owner;
                    end
                end
                default: begin
                    state_q  <= ST_IDLE;
                    wd_cnt_q <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wishbone_rr_arbiter.sv
// Self-checking bench for wishbone_rr_arbiter with two masters and a
// behavioural slave; grant order comes from a queue-free round-robin model.
module tb_wishbone_rr_arbiter;

    localparam int NM = 2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int TO = 16;
    localparam logic [DW-1:0] TIMER_VAL = 32'h0000_1234;

    logic              clk_i   = 1'b0;
    logic              rst_n_i = 1'b0;
    logic [NM-1:0]     m_cyc   = '0;
    logic [NM-1:0]     m_stb   = '0;
    logic [NM-1:0]     m_we    = '0;
    logic [NM*SW-1:0]  m_sel   = '0;
    logic [NM*AW-1:0]  m_addr  = '0;
    logic [NM*DW-1:0]  m_data  = '0;
    logic [DW-1:0]     m_data_o;
    logic [NM-1:0]     m_ack_o;
    logic [NM-1:0]     m_err_o;
    logic [NM-1:0]     grant_o;
    logic              s_cyc_o;
    logic              s_stb_o;
    logic              s_we_o;
    logic [SW-1:0]     s_sel_o;
    logic [AW-1:0]     s_addr_o;
    logic [DW-1:0]     s_data_o;
    logic [DW-1:0]     s_data_i = '0;
    logic              s_ack_i  = 1'b0;

    int total = 0;
    int bad   = 0;
    int model_ptr = 0;
    int ack_cnt [NM];
    logic [AW-1:0] tb_addr  [NM];
    logic [DW-1:0] tb_wdata [NM];
    logic          tb_we    [NM];
    logic [SW-1:0] tb_sel   [NM];

    wishbone_rr_arbiter #(
        .NUM_MASTERS    (NM),
        .ADDR_W         (AW),
        .DATA_W         (DW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk_i    (clk_i),
        .rst_n_i  (rst_n_i),
        .m_cyc_i  (m_cyc),
        .m_stb_i  (m_stb),
        .m_we_i   (m_we),
        .m_sel_i  (m_sel),
        .m_addr_i (m_addr),
        .m_data_i (m_data),
        .m_data_o (m_data_o),
        .m_ack_o  (m_ack_o),
        .m_err_o  (m_err_o),
        .grant_o  (grant_o),
        .s_cyc_o  (s_cyc_o),
        .s_stb_o  (s_stb_o),
        .s_we_o   (s_we_o),
        .s_sel_o  (s_sel_o),
        .s_addr_o (s_addr_o),
        .s_data_o (s_data_o),
        .s_data_i (s_data_i),
        .s_ack_i  (s_ack_i)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    function automatic logic [NM-1:0] oh(input int i);
        logic [NM-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    // Round-robin rule: first pending master at or after the pointer.
    function automatic int model_pick(input int ptr, input logic [NM-1:0] pend);
        for (int k = 0; k < NM; k++) begin
            if (pend[(ptr + k) % NM]) return (ptr + k) % NM;
        end
        return -1;
    endfunction

    task automatic tick();
        @(negedge clk_i);
    endtask

    task automatic drive_master(input int i, input logic we, input logic [SW-1:0] sel,
                                input logic [AW-1:0] addr, input logic [DW-1:0] data);
        m_cyc[i] = 1'b1;
        m_stb[i] = 1'b1;
        m_we[i]  = we;
        m_sel[i*SW +: SW]  = sel;
        m_addr[i*AW +: AW] = addr;
        m_data[i*DW +: DW] = data;
        tb_we[i] = we; tb_sel[i] = sel; tb_addr[i] = addr; tb_wdata[i] = data;
    endtask

    task automatic drive_random(input int i);
        drive_master(i, 1'($urandom_range(0, 1)), SW'($urandom), $urandom, $urandom);
    endtask

    task automatic release_master(input int i);
        m_cyc[i] = 1'b0;
        m_stb[i] = 1'b0;
    endtask

    // All masters in mask request together from IDLE; each owner runs nstb
    // strobes with lat wait states, then releases. 0 / -1 mean randomise.
    task automatic run_round(input logic [NM-1:0] mask, input int nstb_fix, input int lat_fix,
                             output logic [NM-1:0] first_grant);
        logic [NM-1:0] pend;
        logic [DW-1:0] rdata;
        int exp, nstb, lat;
        pend = mask;
        first_grant = '0;
        tick();
        for (int i = 0; i < NM; i++) if (mask[i]) drive_random(i);
        #1;
        total++; if (grant_o !== '0) begin bad++; $display("FAIL idle_grant: got %b want %b", grant_o, {NM{1'b0}}); end
        tick();
        while (pend != '0) begin
            exp = model_pick(model_ptr, pend);
            #1;
            if (first_grant == '0) first_grant = grant_o;
            total++; if (grant_o !== oh(exp)) begin bad++; $display("FAIL grant: got %b want %b", grant_o, oh(exp)); end
            nstb = (nstb_fix > 0) ? nstb_fix : $urandom_range(1, 3);
            for (int s = 0; s < nstb; s++) begin
                lat = (lat_fix >= 0) ? lat_fix : $urandom_range(0, 2);
                for (int l = 0; l < lat; l++) begin
                    s_ack_i = 1'b0;
                    #1;
                    total++; if (m_ack_o !== '0 || s_stb_o !== 1'b1 || grant_o !== oh(exp)) begin
                        bad++; $display("FAIL stall: got ack=%b stb=%b gnt=%b want ack=0 stb=1 gnt=%b", m_ack_o, s_stb_o, grant_o, oh(exp));
                    end
                    tick();
                end
                rdata    = $urandom;
                s_data_i = rdata;
                s_ack_i  = 1'b1;
                #1;
                for (int i = 0; i < NM; i++) if (m_ack_o[i]) ack_cnt[i]++;
                total++; if (m_ack_o !== oh(exp) || m_err_o !== '0) begin
                    bad++; $display("FAIL ack: got ack=%b err=%b want ack=%b err=0", m_ack_o, m_err_o, oh(exp));
                end
                total++; if (m_data_o !== rdata) begin bad++; $display("FAIL rdata: got %h want %h", m_data_o, rdata); end
                total++; if ({s_addr_o, s_data_o, s_sel_o, s_we_o} !== {tb_addr[exp], tb_wdata[exp], tb_sel[exp], tb_we[exp]}) begin
                    bad++; $display("FAIL slave_mux: got %h/%h/%h/%b want %h/%h/%h/%b", s_addr_o, s_data_o, s_sel_o, s_we_o,
                                    tb_addr[exp], tb_wdata[exp], tb_sel[exp], tb_we[exp]);
                end
                tick();
                s_ack_i = 1'b0;
                if (s < nstb - 1) drive_random(exp);
            end
            release_master(exp);
            pend[exp] = 1'b0;
            model_ptr = (exp + 1) % NM;
            #1;
            total++; if (s_cyc_o !== 1'b0) begin bad++; $display("FAIL release_cyc: got %b want 0", s_cyc_o); end
            tick();
            #1;
            total++; if (grant_o !== '0) begin bad++; $display("FAIL dead_cycle: got %b want %b", grant_o, {NM{1'b0}}); end
            tick();
        end
    endtask

    task automatic test_reset();
        drive_random(0);
        #1;
        total++; if ({grant_o, m_ack_o, m_err_o, s_cyc_o, s_stb_o} !== '0) begin
            bad++; $display("FAIL reset_outputs: got gnt=%b ack=%b err=%b cyc=%b stb=%b want all 0", grant_o, m_ack_o, m_err_o, s_cyc_o, s_stb_o);
        end
        tick(); tick();
        total++; if (grant_o !== '0 || s_cyc_o !== 1'b0) begin bad++; $display("FAIL reset_hold: got gnt=%b cyc=%b want 0", grant_o, s_cyc_o); end
        release_master(0);
        tick();
        rst_n_i = 1'b1;
        model_ptr = 0;
        tick();
    endtask

    task automatic test_contention();
        logic [NM-1:0] first;
        run_round(2'b11, 1, 1, first);
        total++; if (first !== 2'b01) begin bad++; $display("FAIL contention_first: got %b want 01", first); end
        run_round(2'b11, 1, 1, first);
        total++; if (first !== 2'b01) begin bad++; $display("FAIL contention_again: got %b want 01", first); end
    endtask

    task automatic test_single_master();
        tick();
        s_ack_i = 1'b1;
        #1;
        total++; if (m_ack_o !== '0) begin bad++; $display("FAIL idle_ack_ignored: got %b want 00", m_ack_o); end
        tick();
        s_ack_i = 1'b0;
        drive_master(1, 1'b0, 4'hF, 32'h0000_0010, '0);
        tick();
        #1;
        total++; if (grant_o !== 2'b10 || s_stb_o !== 1'b1 || s_addr_o !== 32'h0000_0010 || m_ack_o !== '0) begin
            bad++; $display("FAIL single_grant: got gnt=%b stb=%b addr=%h ack=%b want 10/1/00000010/00", grant_o, s_stb_o, s_addr_o, m_ack_o);
        end
        tick();
        s_data_i = TIMER_VAL;
        s_ack_i  = 1'b1;
        #1;
        total++; if (m_ack_o !== 2'b10 || m_data_o !== TIMER_VAL) begin
            bad++; $display("FAIL single_ack: got ack=%b data=%h want 10/%h", m_ack_o, m_data_o, TIMER_VAL);
        end
        tick();
        s_ack_i = 1'b0;
        release_master(1);
        model_ptr = 0;
        tick(); tick();
    endtask

    task automatic test_burst_hold();
        logic [NM-1:0] first;
        ack_cnt[0] = 0;
        ack_cnt[1] = 0;
        run_round(2'b11, 3, 1, first);
        total++; if (first !== 2'b01) begin bad++; $display("FAIL burst_first: got %b want 01", first); end
        total++; if (ack_cnt[0] != 3 || ack_cnt[1] != 3) begin
            bad++; $display("FAIL burst_acks: got %0d/%0d want 3/3", ack_cnt[0], ack_cnt[1]);
        end
    endtask

    task automatic test_timeout();
        int first_err = -1;
        int nerr = 0;
        int nack = 0;
        tick();
        drive_random(1);
        for (int k = 1; k <= 25; k++) begin
            tick();
            #1;
            if (m_ack_o !== '0) nack++;
            if (m_err_o !== '0) begin
                nerr++;
                if (first_err < 0) first_err = k;
                total++; if (m_err_o !== 2'b10 || s_stb_o !== 1'b0 || s_cyc_o !== 1'b0) begin
                    bad++; $display("FAIL abort_cycle: got err=%b stb=%b cyc=%b want 10/0/0", m_err_o, s_stb_o, s_cyc_o);
                end
            end
        end
        total++; if (first_err != TO + 1) begin bad++; $display("FAIL timeout_cycle: got %0d want %0d", first_err, TO + 1); end
        total++; if (nerr != 1 || nack != 0) begin bad++; $display("FAIL timeout_pulse: got err=%0d ack=%0d want 1/0", nerr, nack); end
        release_master(1);
        model_ptr = 0;
        tick(); tick();
    endtask

    task automatic test_ack_boundary();
        int nerr = 0;
        tick();
        drive_random(0);
        for (int k = 1; k <= TO; k++) begin
            tick();
            if (k == TO) begin
                s_data_i = $urandom;
                s_ack_i  = 1'b1;
            end
            #1;
            if (m_err_o !== '0) nerr++;
            if (k == TO) begin
                total++; if (m_ack_o !== 2'b01) begin bad++; $display("FAIL boundary_ack: got %b want 01", m_ack_o); end
            end
        end
        tick();
        s_ack_i = 1'b0;
        release_master(0);
        #1;
        if (m_err_o !== '0) nerr++;
        total++; if (nerr != 0) begin bad++; $display("FAIL boundary_err: got %0d err cycles want 0", nerr); end
        model_ptr = 1;
        tick(); tick();
    endtask

    task automatic test_async_reset();
        logic [NM-1:0] first;
        run_round(2'b01, 1, 1, first);
        tick();
        drive_random(1);
        tick();
        #1;
        s_ack_i = 1'b1;
        #1;
        total++; if (m_ack_o !== 2'b10) begin bad++; $display("FAIL pre_reset_ack: got %b want 10", m_ack_o); end
        rst_n_i = 1'b0;
        #1;
        total++; if ({grant_o, s_cyc_o, s_stb_o, m_ack_o, m_err_o} !== '0) begin
            bad++; $display("FAIL async_reset: got gnt=%b cyc=%b stb=%b ack=%b err=%b want all 0", grant_o, s_cyc_o, s_stb_o, m_ack_o, m_err_o);
        end
        s_ack_i = 1'b0;
        release_master(1);
        model_ptr = 0;
        tick();
        rst_n_i = 1'b1;
        tick();
        run_round(2'b11, 1, 1, first);
        total++; if (first !== 2'b01) begin bad++; $display("FAIL post_reset_first: got %b want 01", first); end
    endtask

    task automatic test_random();
        logic [NM-1:0] first;
        for (int r = 0; r < 20; r++) begin
            run_round(NM'($urandom_range(1, 3)), 0, -1, first);
        end
    endtask

    initial begin
        test_reset();
        test_contention();
        test_single_master();
        test_burst_hold();
        test_timeout();
        test_ack_boundary();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
